// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ requesters.
// Each requester owns a one-byte holding slot; bytes are issued one at a time, paced by i_tx_busy.
module uart_tx_arbiter #(
    parameter int N_REQ         = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req_transmit,
    input  logic [8*N_REQ-1:0] i_req_data,
    output logic [N_REQ-1:0]   o_req_drop,
    output logic [N_REQ-1:0]   o_pending,
    input  logic               i_tx_busy,
    output logic               o_tx_transmit,
    output logic [7:0]         o_tx_data
);
    localparam int LGW = $clog2(N_REQ);
    localparam int CW  = $clog2(START_TIMEOUT) + 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] WAIT_START = 2'd1;
    localparam logic [1:0] WAIT_DONE  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]         state_reg;
    logic [LGW-1:0]     last_grant_reg;
    logic [CW-1:0]      timeout_cnt_reg;
    logic [N_REQ-1:0]   pending_reg;
    logic [N_REQ-1:0]   pending_next;
    logic [N_REQ-1:0]   drop_reg;
    logic [N_REQ-1:0]   drop_next;
    logic               tx_transmit_reg;
    logic [7:0]         tx_data_reg;
    logic [8*N_REQ-1:0] slot_flat;

    logic               grant_valid;
    logic [LGW-1:0]     grant_idx;
    logic [7:0]         grant_data;
    logic [N_REQ-1:0]   grant_mask;
    int                 cand;

    // A slot may be refilled on the very edge its old byte is granted out.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
            logic [7:0] slot_reg;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    slot_reg <= 8'h00;
                end else if (i_req_transmit[gi] && (!pending_reg[gi] || grant_mask[gi])) begin
                    slot_reg <= i_req_data[8*gi +: 8];
                end
            end
            assign slot_flat[8*gi +: 8] = slot_reg;
        end
    endgenerate

    // Search starts just after the last granted requester, wrapping modulo N_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_data  = 8'h00;
        grant_mask  = '0;
        cand        = 0;
        if (state_reg == IDLE && !i_tx_busy) begin
            for (int i = 1; i <= N_REQ; i++) begin
                cand = (int'(last_grant_reg) + i) % N_REQ;
                if (!grant_valid && pending_reg[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = LGW'(cand);
                    grant_data  = slot_flat[8*cand +: 8];
                end
            end
        end
        if (grant_valid) begin
            grant_mask[grant_idx] = 1'b1;
        end
    end

    assign pending_next = (pending_reg & ~grant_mask) | i_req_transmit;
    assign drop_next    = i_req_transmit & pending_reg & ~grant_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= IDLE;
            last_grant_reg  <= LGW'(N_REQ - 1);
            timeout_cnt_reg <= '0;
            pending_reg     <= '0;
            drop_reg        <= '0;
            tx_transmit_reg <= 1'b0;
            tx_data_reg     <= 8'h00;
        end else begin
            pending_reg     <= pending_next;
            drop_reg        <= drop_next;
            tx_transmit_reg <= grant_valid;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        tx_data_reg     <= grant_data;
                        last_grant_reg  <= grant_idx;
                        timeout_cnt_reg <= '0;
                        state_reg       <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    // A transmitter that never reports busy still releases the arbiter.
                    if (i_tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (timeout_cnt_reg == CNT_LAST) begin
                        state_reg <= IDLE;
                    end else if (timeout_cnt_reg != CNT_MAX) begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_pending     = pending_reg;
    assign o_req_drop    = drop_reg;
    assign o_tx_transmit = tx_transmit_reg;
    assign o_tx_data     = tx_data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table plus scoreboard of emitted bytes,
// with a simple transmitter busy model.
module tb_uart_tx_arbiter;
    logic        i_clk;
    logic        i_rst;
    logic [3:0]  i_req_transmit;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_drop;
    logic [3:0]  o_pending;
    logic        i_tx_busy;
    logic        o_tx_transmit;
    logic [7:0]  o_tx_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb [$];
    logic       model_busy = 1'b0;
    logic       model_en   = 1'b1;
    logic       force_busy = 1'b0;
    int         phase      = 0;
    int         busy_dly   = 2;
    int         busy_len   = 10;
    int         cyc        = 0;
    logic       busy_at_edge = 1'b0;
    int         last_pulse_cyc = 0;
    int         last_gap   = 0;
    logic       pulse_seen = 1'b0;
    logic [7:0] exp_b;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          n;
        logic [31:0] exp_flat;
    } vec_t;
    vec_t vecs [3];

    assign i_tx_busy = (model_en & model_busy) | force_busy;

    uart_tx_arbiter #(.N_REQ(4), .START_TIMEOUT(16)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_transmit (i_req_transmit),
        .i_req_data     (i_req_data),
        .o_req_drop     (o_req_drop),
        .o_pending      (o_pending),
        .i_tx_busy      (i_tx_busy),
        .o_tx_transmit  (o_tx_transmit),
        .o_tx_data      (o_tx_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) begin
        cyc          <= cyc + 1;
        busy_at_edge <= i_tx_busy;
    end

    // Output monitor (scoreboard pop) followed by the transmitter busy model.
    always @(negedge i_clk) begin
        if (o_tx_transmit) begin
            checks++;
            if (busy_at_edge) begin
                failures++;
                $display("FAIL grant_while_busy actual=pulse required=no_pulse byte=%02h", o_tx_data);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_byte actual=%02h required=none", o_tx_data);
            end else begin
                exp_b = sb.pop_front();
                if (o_tx_data !== exp_b) begin
                    failures++;
                    $display("FAIL tx_data actual=%02h required=%02h", o_tx_data, exp_b);
                end else begin
                    $display("tx byte %02h at cycle %0d", o_tx_data, cyc);
                end
            end
            if (pulse_seen) begin
                last_gap = cyc - last_pulse_cyc;
                checks++;
                if (last_gap < 3) begin
                    failures++;
                    $display("FAIL grant_spacing actual=%0d required>=3", last_gap);
                end
            end
            last_pulse_cyc = cyc;
            pulse_seen     = 1'b1;
        end
        if (o_tx_transmit) phase = 1;
        else if (phase != 0) phase++;
        if (phase > busy_dly + busy_len) phase = 0;
        model_busy = (phase > busy_dly) && (phase <= busy_dly + busy_len);
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic [3:0] mask, input logic [31:0] data);
        i_req_transmit = mask;
        i_req_data     = data;
        step();
        i_req_transmit = 4'b0000;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || o_pending != 4'b0000 || i_tx_busy) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d_left required=0", sb.size());
        end
        repeat (20) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{mask: 4'b0111, data: 32'h00647361, n: 3, exp_flat: 32'h00647361};
        vecs[1] = '{mask: 4'b0101, data: 32'h00640061, n: 2, exp_flat: 32'h00006461};
        vecs[2] = '{mask: 4'b1111, data: 32'hA3A2A1A0, n: 4, exp_flat: 32'hA2A1A0A3};

        i_rst          = 1'b1;
        i_req_transmit = 4'b0000;
        i_req_data     = 32'h0;
        repeat (3) step();
        chk("rst_pending", {28'h0, o_pending}, 32'h0);
        chk("rst_drop", {28'h0, o_req_drop}, 32'h0);
        chk("rst_transmit", {31'h0, o_tx_transmit}, 32'h0);
        chk("rst_data", {24'h0, o_tx_data}, 32'h0);
        i_rst = 1'b0;
        step();

        // Round-robin fairness table
        for (int v = 0; v < 3; v++) begin
            for (int b = 0; b < vecs[v].n; b++) sb.push_back(vecs[v].exp_flat[8*b +: 8]);
            drive(vecs[v].mask, vecs[v].data);
            $display("vector %0d mask=%b pending=%b", v, vecs[v].mask, o_pending);
            chk("vec_pending", {28'h0, o_pending}, {28'h0, vecs[v].mask});
            chk("vec_drop", {28'h0, o_req_drop}, 32'h0);
            drain(300);
        end

        // Single request: latency and pending clear
        sb.push_back(8'h77);
        drive(4'b0001, 32'h00000077);
        chk("single_pending", {28'h0, o_pending}, 32'h1);
        chk("single_no_early_pulse", {31'h0, o_tx_transmit}, 32'h0);
        step();
        chk("single_latency", {31'h0, o_tx_transmit}, 32'h1);
        chk("single_data", {24'h0, o_tx_data}, 32'h77);
        chk("single_pending_clear", {28'h0, o_pending}, 32'h0);
        drain(200);

        // Overflow while the transmitter is held busy
        force_busy = 1'b1;
        sb.push_back(8'h11);
        drive(4'b0010, 32'h00001100);
        chk("ovf_pending", {28'h0, o_pending}, 32'h2);
        chk("ovf_first_drop", {28'h0, o_req_drop}, 32'h0);
        drive(4'b0010, 32'h00002200);
        chk("ovf_drop", {28'h0, o_req_drop}, 32'h2);
        step();
        chk("ovf_drop_once", {28'h0, o_req_drop}, 32'h0);
        chk("ovf_no_grant", {31'h0, o_tx_transmit}, 32'h0);
        force_busy = 1'b0;
        drain(200);

        // Same-edge refill of slot 3
        force_busy = 1'b1;
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        drive(4'b1000, 32'h55000000);
        force_busy = 1'b0;
        drive(4'b1000, 32'hAA000000);
        chk("refill_grant", {31'h0, o_tx_transmit}, 32'h1);
        chk("refill_pending", {28'h0, o_pending}, 32'h8);
        chk("refill_drop", {28'h0, o_req_drop}, 32'h0);
        drain(200);

        // Start timeout: transmitter never reports busy
        model_en = 1'b0;
        sb.push_back(8'h01);
        drive(4'b0001, 32'h00000001);
        step();
        chk("to_first_grant", {31'h0, o_tx_transmit}, 32'h1);
        repeat (18) step();
        sb.push_back(8'h02);
        drive(4'b0001, 32'h00000002);
        chk("to_second_pending", {28'h0, o_pending}, 32'h1);
        step();
        chk("to_second_grant", {31'h0, o_tx_transmit}, 32'h1);
        sb.push_back(8'h33);
        drive(4'b0010, 32'h00003300);
        drain(200);
        chk("to_gap", last_gap, 32'd17);
        model_en = 1'b1;

        // Reset during WAIT_DONE with two slots still pending
        sb.push_back(8'hD3);
        drive(4'b1011, 32'hD300B1B0);
        begin
            int n;
            n = 0;
            while (!i_tx_busy && n < 30) begin
                step();
                n++;
            end
            chk("rst_mid_busy_seen", {31'h0, i_tx_busy}, 32'h1);
        end
        chk("rst_mid_pending_before", {28'h0, o_pending}, 32'h3);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_mid_pending", {28'h0, o_pending}, 32'h0);
        chk("rst_mid_transmit", {31'h0, o_tx_transmit}, 32'h0);
        chk("rst_mid_data", {24'h0, o_tx_data}, 32'h0);
        chk("rst_mid_drop", {28'h0, o_req_drop}, 32'h0);
        sb.delete();
        step();
        step();
        i_rst = 1'b0;
        sb.push_back(8'hC2);
        drive(4'b0100, 32'h00C20000);
        chk("post_rst_pending", {28'h0, o_pending}, 32'h4);
        drain(200);

        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
